// File: rtl/ccff_loader.sv
// ccff_loader: configuration-chain loader for the FPGA fabric.
// Accepts bitstream bytes over valid/ready and shifts them MSB-first into the
// chain head, one prog_en per bit. Bits falling out of the chain tail are
// captured per byte and presented on tail_byte with a tail_valid pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      begin a load (IDLE/DONE only) / return to IDLE
//   byte_in/valid     bitstream byte and its valid; byte_ready accepts it
//   ccff_head         serial data to the chain head
//   prog_en           chain shift enable (chain shifts on clk when 1)
//   ccff_tail         serial data from the chain tail
//   tail_byte/valid   captured tail bits for the last byte, one-cycle pulse
//   busy, done        LOAD/SHIFT in progress; all CHAIN_LEN bits shifted
module ccff_loader #(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       ccff_head,
    output logic       prog_en,
    input  logic       ccff_tail,
    output logic [7:0] tail_byte,
    output logic       tail_valid,
    output logic       busy,
    output logic       done
);

    // Remaining-bit arithmetic needs at least 4 bits to hold the value 8.
    localparam int unsigned RW = (CNT_W > 4) ? CNT_W : 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nb_q, nb_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       tsr_q, tsr_d;
    logic [7:0]       tbyte_q, tbyte_d;
    logic             tvalid_q, tvalid_d;
    logic             done_q, done_d;
    logic             head_q, head_d;
    logic             pen_q, pen_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic [RW-1:0]    remain;
    logic [3:0]       nb_load;
    logic [CNT_W-1:0] cnt_inc;

    // Bits still owed to the chain, and the size of the next byte slice.
    assign remain  = RW'(CHAIN_LEN) - RW'(cnt_q);
    assign nb_load = (remain >= RW'(8)) ? 4'd8 : remain[3:0];
    assign cnt_inc = cnt_q + CNT_W'(1);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            nb_q     <= '0;
            data_q   <= '0;
            tsr_q    <= '0;
            tbyte_q  <= '0;
            tvalid_q <= 1'b0;
            done_q   <= 1'b0;
            head_q   <= 1'b0;
            pen_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nb_q     <= nb_d;
            data_q   <= data_d;
            tsr_q    <= tsr_d;
            tbyte_q  <= tbyte_d;
            tvalid_q <= tvalid_d;
            done_q   <= done_d;
            head_q   <= head_d;
            pen_q    <= pen_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nb_d     = nb_q;
        data_d   = data_q;
        tsr_d    = tsr_q;
        tbyte_d  = tbyte_q;
        tvalid_d = 1'b0;
        done_d   = done_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            LOAD: begin
                if (byte_valid) begin
                    data_d  = byte_in;
                    tsr_d   = '0;
                    nb_d    = nb_load;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                data_d = {data_q[6:0], 1'b0};
                tsr_d  = {tsr_q[6:0], ccff_tail};
                cnt_d  = cnt_inc;
                nb_d   = nb_q - 4'd1;
                // Last bit of this slice: publish the tail bits including this edge's capture.
                if (nb_q == 4'd1) begin
                    tbyte_d  = tsr_d;
                    tvalid_d = 1'b1;
                    if (cnt_inc == CNT_W'(CHAIN_LEN)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_d   = 1'b0;
            tvalid_d = 1'b0;
        end

        // Outputs are registered copies of the next-state decode.
        pen_d  = (state_d == SHIFT);
        rdy_d  = (state_d == LOAD);
        busy_d = pen_d | rdy_d;
        head_d = pen_d & data_d[7];
    end

    assign byte_ready = rdy_q;
    assign ccff_head  = head_q;
    assign prog_en    = pen_q;
    assign tail_byte  = tbyte_q;
    assign tail_valid = tvalid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader for the on-chip FPGA fabric. It accepts a bitstream one byte at a time over a valid/ready handshake and serializes it MSB-first onto the fabric's `ccff_head` input. It generates one `prog_en` clock-enable per bit and, on the same edge, captures the bit falling out of `ccff_tail` so the host can read back or verify the previous contents. It sits between the top-level pin interface and the fabric's configuration port: it is the writer for the chain whose tail the fabric exposes.

## Interface
Parameters:
- `CHAIN_LEN`, default 1024: total configuration bits in the chain; must be ≥ 1.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports:
- `clk`, in, 1: single clock. The chain's programming clock is `clk` gated by `prog_en`.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse that begins a new load. Honoured only in IDLE or DONE.
- `abort`, in, 1: synchronous abort; returns the block to IDLE.
- `byte_in`, in, 8: bitstream byte, transmitted MSB first.
- `byte_valid`, in, 1: `byte_in` is valid.
- `byte_ready`, out, 1: the block accepts `byte_in` this cycle.
- `ccff_head`, out, 1: serial data to the chain head.
- `prog_en`, out, 1: chain shift enable. The chain shifts on each `clk` rising edge where it is 1.
- `ccff_tail`, in, 1: serial data from the chain tail.
- `tail_byte`, out, 8: the bits captured from `ccff_tail` for the last byte.
- `tail_valid`, out, 1: one-cycle pulse; `tail_byte` is updated.
- `busy`, out, 1: the state is LOAD or SHIFT.
- `done`, out, 1: all `CHAIN_LEN` bits have been shifted. Held until `start` or `abort`.

## Operation
- States:
  - IDLE: on `start`, go to LOAD, clear the bit counter, clear `done`.
  - LOAD: `byte_ready`=1. On `byte_valid & byte_ready`:
    - latch `byte_in` into the data shift register;
    - clear the tail shift register;
    - set the per-byte bit count `nb = min(8, CHAIN_LEN - count)`;
    - go to SHIFT.
  - SHIFT: each cycle, `prog_en`=1 and `ccff_head` = data register bit 7.
    - On that edge: shift the data register left by one; shift the tail register with `tail_sr <= {tail_sr[6:0], ccff_tail}`; increment the counter; decrement `nb`.
    - When `nb` reaches 0: `tail_byte <= tail_sr` (including the bit captured on this edge), pulse `tail_valid`.
    - Next state is DONE if the counter equals `CHAIN_LEN`, otherwise LOAD.
  - DONE: `done`=1, `prog_en`=0. `start` goes to LOAD exactly as from IDLE.
- Partial final byte (`CHAIN_LEN` not a multiple of 8):
  - only the upper `nb` bits of the final byte are shifted; the lower bits are discarded;
  - `tail_byte` holds the `nb` captured bits right-aligned, with the upper bits 0.
- `abort` in any state: next state IDLE, counter cleared, `done`=0. `prog_en` is 0 from the cycle after `abort` is sampled. The chain contents are then undefined and the host must restart.
- `abort` and `start` in the same cycle: `abort` wins.
- `start` in LOAD or SHIFT: ignored.
- `byte_valid` outside LOAD: ignored; the byte is held by the host.
- `prog_en` is never 1 outside SHIFT. Exactly `CHAIN_LEN` `prog_en` cycles occur per complete load.

## Timing
- Reset values:
  - state IDLE;
  - `byte_ready`=0, `ccff_head`=0, `prog_en`=0;
  - `tail_byte`=0x00, `tail_valid`=0, `busy`=0, `done`=0;
  - counter 0.
- `ccff_head`, `tail_byte`, `tail_valid` and `done` are registered. `prog_en`, `byte_ready` and `busy` decode the registered state directly, with no input-to-output combinational path.
- Handshake to first bit: a byte accepted on edge N produces SHIFT on cycles N+1 … N+nb, with `ccff_head` showing bit 7 during cycle N+1.
- `tail_valid` is high for the cycle after the last SHIFT edge.
- Throughput: a full byte occupies 1 LOAD cycle plus 8 SHIFT cycles, so 9 cycles per byte with `byte_valid` held high.
- `done` rises in the cycle after the final SHIFT edge, coincident with the last `tail_valid`.
- Reset mid-SHIFT: all outputs return to their reset values asynchronously. No further `prog_en`.

## Test plan
- **Full load, CHAIN_LEN=16.** Sequence: `start`, then bytes 0xA5 and 0x3C, with `ccff_tail` tied to a 16-bit model chain preloaded with 0xFF00.
  - `ccff_head` sequence is 1010010100111100;
  - exactly 16 `prog_en` cycles;
  - `tail_byte` is 0xFF then 0x00;
  - `done`=1 at cycle 19 after `start`.
- **Partial byte, CHAIN_LEN=20.** Bytes 0x12, 0x34, 0xF7 with the tail model all-ones.
  - the third byte shifts only 1111;
  - 20 `prog_en` cycles in total;
  - final `tail_byte` is 0x0F.
- **Backpressure.** Delay `byte_valid` 5 cycles between bytes.
  - `byte_ready` stays high while waiting;
  - `prog_en` stays low while waiting;
  - bitstream identical to the first scenario.
- **Abort mid-SHIFT.** Assert `abort` during the 3rd bit of byte 1.
  - `prog_en`=0 from the next cycle;
  - state IDLE, `busy`=0, `done`=0;
  - a subsequent `start` and full load produce the correct 16-bit stream.
- **Ignored start / simultaneous events.**
  - `start` during SHIFT: no effect on the bitstream.
  - `start` and `abort` in the same IDLE cycle: the block stays in IDLE.
  - `start` in DONE: `done` clears and a new load proceeds.
- **Async reset mid-load.** Drop `rst_n` in SHIFT between clock edges.
  - all outputs reach their reset values immediately;
  - no `prog_en` pulses until a new `start` after `rst_n` is released.
